min_vector_seq: RTL and testbench
=================================

MIN_VECTOR_SEQ -- requirements
Module: min_vector_seq

Interface
REQ-001 SHALL have parameter BITS, default 16, meaning element width in bits.
REQ-002 SHALL have parameter PRECISION, default "HALF", meaning the float format passed unchanged to the datapath.
REQ-003 SHALL have parameter WIDTH, default 4 (minimum 2), meaning datapath lane count; CHUNK = WIDTH-1 elements are accepted per beat.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk input 1 is the clock; all state on rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 start  input  1  starts a run when sampled high in IDLE.
REQ-007 num_beats  input  16  number of beats in the run; sampled with start.
REQ-008 abort  input  1  terminates the current run.
REQ-009 in_valid  input  1  beat offered.
REQ-010 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-011 in_data  input  [BITS-1:0] x CHUNK (unpacked array)  beat elements.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 out_valid  output  1  one-cycle result pulse.
REQ-014 out_empty  output  1  qualifies out_valid: run had zero beats.
REQ-015 out_min  output  BITS  minimum over all accepted elements of the run.

Function
REQ-016 SHALL instantiate one min_vector (BITS, PRECISION, WIDTH); LEVELS = $clog2(WIDTH) = datapath latency in cycles.
REQ-017 SHALL run FSM states IDLE, ACCEPT, ISSUE, WAIT, DONE.
REQ-018 IDLE: start=1 with num_beats>0 -> ACCEPT; load beat counter = num_beats and clear acc_valid.
REQ-019 IDLE: start=1 with num_beats=0 -> DONE with out_empty=1 and out_min=0.
REQ-020 ACCEPT: in_ready=1 (only state with in_ready high); on handshake, load operand register and go to ISSUE.
REQ-021 Operand lanes: lane 0 = acc when acc_valid, else in_data[0]; lanes 1..WIDTH-1 = in_data[0..CHUNK-1].
REQ-022 ISSUE: drive datapath in_valid high for exactly one cycle with the operand register, then go to WAIT.
REQ-023 WAIT: on datapath out_valid, capture its result into acc, set acc_valid and decrement the beat counter; go to DONE if the counter reaches 0, else ACCEPT.
REQ-024 DONE: out_valid=1 for one cycle with out_min=acc and out_empty=0, or the REQ-019 values; then go to IDLE.
REQ-025 out_min and out_empty SHALL hold their values from DONE until the next DONE.
REQ-026 Latency: the last beat's handshake in cycle t gives out_valid in cycle t+LEVELS+2; maximum throughput is one beat per LEVELS+2 cycles.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 abort SHALL force IDLE on the next edge from any state with no out_valid; it SHALL win over a simultaneous handshake, result capture or start.
REQ-029 An in-flight datapath result after abort SHALL be discarded.
REQ-030 Element ordering and equal values SHALL NOT affect out_min; NaN inputs are out of scope.

Reset
REQ-031 rstn low SHALL asynchronously force IDLE with in_ready=0, busy=0, out_valid=0, out_empty=0, out_min=0, acc=0, acc_valid=0 and beat counter=0.
REQ-032 rstn deasserted mid-run SHALL leave the block in IDLE; the next run SHALL be unaffected by earlier data.

Verification (HALF, WIDTH=4, LEVELS=2)
REQ-033 start, num_beats=1, beat {4000,3C00,4200} handshake at cycle t -> out_valid at t+4 with out_min=3C00 and out_empty=0.
REQ-034 num_beats=3, beats {4000,4200,4400}, {BC00,3C00,4000}, {3800,4000,4200} -> a single out_valid with out_min=BC00; in_ready low for 3 cycles after each handshake.
REQ-035 start with num_beats=0 -> out_valid the next cycle with out_empty=1 and out_min=0; in_ready never high.
REQ-036 abort in the WAIT state of beat 2 of 3 -> no out_valid and busy=0 next cycle; a new 1-beat run {4400,4200,4000} gives out_min=4000.
REQ-037 rstn pulse during ACCEPT, then in_valid held high -> in_ready=0 and busy=0; a second start during a run is ignored and the beat count is unchanged.

Source files
------------

// File: rtl/min_vector_seq.sv
// min_vector: pipelined min-reduction tree over WIDTH lanes.
// Latency $clog2(WIDTH) cycles, one operand set per cycle; no backpressure.
// Float lanes use the IEEE total order by sign/magnitude, so -0 ranks below +0.
module min_vector #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF",
    parameter int    WIDTH     = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [BITS-1:0] in_data [WIDTH],
    output logic            out_valid,
    output logic [BITS-1:0] out_data
);
    localparam int  LEVELS = $clog2(WIDTH);
    localparam int  NP     = 1 << LEVELS;
    localparam bit  IS_INT = (PRECISION == "INT");

    function automatic logic lt(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        if (IS_INT)
            return $signed(a) < $signed(b);
        if (a[BITS-1] != b[BITS-1])
            return a[BITS-1];
        if (a[BITS-1])
            return a[BITS-2:0] > b[BITS-2:0];
        return a[BITS-2:0] < b[BITS-2:0];
    endfunction

    logic [BITS-1:0] lanes [NP];
    logic [LEVELS-1:0] vld_q;

    // Missing lanes duplicate lane 0, which can never change the minimum.
    for (genvar i = 0; i < NP; i++) begin : g_pad
        if (i < WIDTH) begin : g_in
            assign lanes[i] = in_data[i];
        end else begin : g_dup
            assign lanes[i] = in_data[0];
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N = NP >> (l + 1);
        logic [BITS-1:0] prev [2*N];
        logic [BITS-1:0] q [N];

        if (l == 0) begin : g_leaf
            assign prev = lanes;
        end else begin : g_inner
            assign prev = g_lvl[l-1].q;
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int i = 0; i < N; i++) q[i] <= '0;
            end else begin
                for (int i = 0; i < N; i++)
                    q[i] <= lt(prev[2*i+1], prev[2*i]) ? prev[2*i+1] : prev[2*i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) vld_q <= '0;
        else       vld_q <= (vld_q << 1) | LEVELS'(in_valid);
    end

    assign out_valid = vld_q[LEVELS-1];
    assign out_data  = g_lvl[LEVELS-1].q[0];
endmodule

// min_vector_seq: folds a run of WIDTH-1 element beats into one minimum via min_vector.
// Latency: last beat handshake at t -> out_valid at t+LEVELS+2; one beat per LEVELS+2 cycles.
// Backpressure: in_ready only in ACCEPT; abort drops the run and any in-flight result.
module min_vector_seq #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF",
    parameter int    WIDTH     = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [15:0]     num_beats,
    input  logic            abort,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_data [WIDTH-1],
    output logic            busy,
    output logic            out_valid,
    output logic            out_empty,
    output logic [BITS-1:0] out_min
);
    localparam int CHUNK = WIDTH - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_ISSUE, S_WAIT, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     beats_q;
    logic [BITS-1:0] acc_q;
    logic            acc_valid_q;
    logic [BITS-1:0] op_q [WIDTH];
    logic            inflight_q, stale_q;
    logic            dp_in_valid, dp_out_valid, capture;
    logic [BITS-1:0] dp_out;

    min_vector #(.BITS(BITS), .PRECISION(PRECISION), .WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (dp_in_valid),
        .in_data   (op_q),
        .out_valid (dp_out_valid),
        .out_data  (dp_out)
    );

    // A result left over from an aborted run is flagged stale and skipped.
    assign capture = (state_q == S_WAIT) && dp_out_valid && !stale_q && !abort;

    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        dp_in_valid = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (start) state_d = (num_beats == 16'd0) ? S_DONE : S_ACCEPT;
                S_ACCEPT: begin
                    in_ready = 1'b1;
                    if (in_valid) state_d = S_ISSUE;
                end
                S_ISSUE:  begin
                    dp_in_valid = 1'b1;
                    state_d     = S_WAIT;
                end
                S_WAIT:   if (capture) state_d = (beats_q == 16'd1) ? S_DONE : S_ACCEPT;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beats_q     <= '0;
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
            out_min     <= '0;
            out_empty   <= 1'b0;
            inflight_q  <= 1'b0;
            stale_q     <= 1'b0;
            for (int i = 0; i < WIDTH; i++) op_q[i] <= '0;
        end else begin
            if (dp_in_valid)       inflight_q <= 1'b1;
            else if (dp_out_valid) inflight_q <= 1'b0;

            if (dp_out_valid)                 stale_q <= 1'b0;
            else if (abort && inflight_q)     stale_q <= 1'b1;

            if (!abort) begin
                if (state_q == S_IDLE && start) begin
                    beats_q     <= num_beats;
                    acc_valid_q <= 1'b0;
                    if (num_beats == 16'd0) begin
                        out_min   <= '0;
                        out_empty <= 1'b1;
                    end
                end
                if (state_q == S_ACCEPT && in_valid) begin
                    op_q[0] <= acc_valid_q ? acc_q : in_data[0];
                    for (int k = 0; k < CHUNK; k++) op_q[k+1] <= in_data[k];
                end
                if (capture) begin
                    acc_q       <= dp_out;
                    acc_valid_q <= 1'b1;
                    beats_q     <= beats_q - 16'd1;
                    if (beats_q == 16'd1) begin
                        out_min   <= dp_out;
                        out_empty <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_min_vector_seq.sv
// Bench for min_vector_seq (HALF, WIDTH=4): vector table, scoreboard with latency
// tracking, and hand-written abort / reset / ignored-start sequences.
module tb_min_vector_seq;
    localparam int BITS  = 16;
    localparam int WIDTH = 4;
    localparam int CHUNK = WIDTH - 1;
    localparam int LAT   = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic            start = 1'b0;
    logic [15:0]     num_beats = '0;
    logic            abort = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready, busy, out_valid, out_empty;
    logic [BITS-1:0] in_data [CHUNK];
    logic [BITS-1:0] out_min;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic ready_seen = 1'b0;

    typedef struct { logic [15:0] min; logic empty; int due; } exp_t;
    exp_t sb[$];

    typedef struct { logic [15:0] d0; logic [15:0] d1; logic [15:0] d2; logic [15:0] exp; } vec_t;
    vec_t vt [7];

    min_vector_seq #(.BITS(BITS), .PRECISION("HALF"), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .num_beats (num_beats),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_empty (out_empty),
        .out_min   (out_min)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (in_ready === 1'b1) ready_seen = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rstn && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, expected 0", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_min", 32'(out_min), 32'(e.min));
                check("out_empty", 32'(out_empty), 32'(e.empty));
                check("latency", cyc, e.due);
            end
        end
    end

    task automatic push_exp(input logic [15:0] m, input logic e, input int due);
        exp_t x;
        x.min = m; x.empty = e; x.due = due;
        sb.push_back(x);
    endtask

    task automatic start_run(input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; num_beats = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                             output int hs);
        in_valid = 1'b1;
        in_data[0] = a; in_data[1] = b; in_data[2] = c;
        hs = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) begin
            total++;
            $display("FAIL beat_timeout: got no in_ready in 64 cycles, expected handshake");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && busy === 1'b0) break;
        end
        if (k == 200) begin
            total++;
            $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [15:0] order_key(input logic [15:0] x);
        return x[15] ? ~x : (x | 16'h8000);
    endfunction

    function automatic logic [15:0] rnd_half();
        logic [15:0] x;
        do x = 16'($urandom);
        while ((x[14:10] == 5'h1F && x[9:0] != 10'd0) || x == 16'h8000);
        return x;
    endfunction

    initial begin
        int h1, h2, h3, s;
        logic [15:0] m, v0, v1, v2;
        in_data = '{default: '0};
        vt[0] = '{16'h4000, 16'h3C00, 16'h4200, 16'h3C00};
        vt[1] = '{16'h4400, 16'h4200, 16'h4000, 16'h4000};
        vt[2] = '{16'hBC00, 16'hC000, 16'h3C00, 16'hC000};
        vt[3] = '{16'h7BFF, 16'h7C00, 16'h0001, 16'h0001};
        vt[4] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
        vt[5] = '{16'hFC00, 16'h0000, 16'h4000, 16'hFC00};
        vt[6] = '{16'h0400, 16'h8001, 16'h0000, 16'h8001};

        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_empty", 32'(out_empty), 32'd0);
        check("rst_out_min", 32'(out_min), 32'd0);
        @(posedge clk); #1 rstn = 1'b1;

        foreach (vt[i]) begin
            start_run(16'd1);
            send_beat(vt[i].d0, vt[i].d1, vt[i].d2, h1);
            push_exp(vt[i].exp, 1'b0, h1 + LAT);
            wait_drain();
        end
        repeat (5) @(negedge clk);
        check("out_min_hold", 32'(out_min), 32'(vt[6].exp));

        // three-beat run with throughput check
        start_run(16'd3);
        send_beat(16'h4000, 16'h4200, 16'h4400, h1);
        send_beat(16'hBC00, 16'h3C00, 16'h4000, h2);
        send_beat(16'h3800, 16'h4000, 16'h4200, h3);
        push_exp(16'hBC00, 1'b0, h3 + LAT);
        check("beat_spacing_1", h2 - h1, 32'd4);
        check("beat_spacing_2", h3 - h2, 32'd4);
        wait_drain();

        // zero-beat run
        ready_seen = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; num_beats = 16'd0;
        @(negedge clk);
        s = cyc;
        push_exp(16'h0000, 1'b1, s + 1);
        @(posedge clk); #1 start = 1'b0;
        wait_drain();
        check("zero_run_no_ready", 32'(ready_seen), 32'd0);

        // abort during WAIT of beat 2 of 3
        start_run(16'd3);
        send_beat(16'h4000, 16'h4200, 16'h4400, h1);
        send_beat(16'h3800, 16'h3A00, 16'h3C00, h2);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        repeat (5) @(negedge clk);
        start_run(16'd1);
        send_beat(16'h4400, 16'h4200, 16'h4000, h1);
        push_exp(16'h4000, 1'b0, h1 + LAT);
        wait_drain();

        // reset pulse during ACCEPT, then a run with an ignored second start
        start_run(16'd2);
        send_beat(16'h3000, 16'h5000, 16'h5000, h1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
        end
        #1 rstn = 1'b0;
        #1;
        check("rstpulse_in_ready", 32'(in_ready), 32'd0);
        check("rstpulse_busy", 32'(busy), 32'd0);
        in_valid = 1'b1;
        @(posedge clk); #1 rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_in_ready", 32'(in_ready), 32'd0);
        end
        check("post_rst_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        start_run(16'd2);
        send_beat(16'h4200, 16'h4400, 16'h4600, h1);
        @(posedge clk); #1 start = 1'b1; num_beats = 16'd5;
        @(posedge clk); #1 start = 1'b0;
        send_beat(16'h4000, 16'h4800, 16'h4A00, h2);
        push_exp(16'h4000, 1'b0, h2 + LAT);
        wait_drain();

        // random multi-beat runs against an order-key model
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 4);
            start_run(16'(n));
            m = 16'h7C00;
            for (int b = 0; b < n; b++) begin
                v0 = rnd_half(); v1 = rnd_half(); v2 = rnd_half();
                if (order_key(v0) < order_key(m)) m = v0;
                if (order_key(v1) < order_key(m)) m = v1;
                if (order_key(v2) < order_key(m)) m = v2;
                send_beat(v0, v1, v2, h1);
            end
            push_exp(m, 1'b0, h1 + LAT);
            wait_drain();
        end

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
